// File: rtl/i2c_target_regbank.sv
// i2c_target_regbank: I2C target engine that maps an external I2C controller
// onto a host RAM or register file with 1-cycle read latency.
//
// Ports:
//   clk_clk, reset_reset_n        system clock, async active-low reset
//   i2c_data_in, i2c_clk_in       SDA / SCL pin levels
//   i2c_data_oe, i2c_clk_oe       1 = pull SDA / SCL low (never driven high)
//   mem_address                   current pointer (wraps modulo 2^ADDR_WIDTH)
//   mem_write, mem_writedata      one-cycle write strobe and its byte
//   mem_read, mem_readdata        one-cycle read strobe; data valid next cycle
//   busy                          address matched, transaction not yet STOPped
//   xfer_count                    data bytes in current/last transaction (saturating)
module i2c_target_regbank #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         PTR_BYTES   = 1,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         FILTER_LEN  = 3,
    parameter bit         STRETCH_EN  = 1'b1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  i2c_data_in,
    input  logic                  i2c_clk_in,
    output logic                  i2c_data_oe,
    output logic                  i2c_clk_oe,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write,
    output logic [7:0]            mem_writedata,
    output logic                  mem_read,
    input  logic [7:0]            mem_readdata,
    output logic                  busy,
    output logic [15:0]           xfer_count
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int PW = 8 * PTR_BYTES;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK,
        RD_FETCH, READ, RD_ACK, WAIT_STOP
    } state_e;

    // ---------------- input synchronise + run filter (bit0 = SDA, bit1 = SCL)
    logic [1:0] pin_raw, filt_w, prev_w;
    assign pin_raw = {i2c_clk_in, i2c_data_in};

    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic          sync1_q, sync2_q, filt_q, prev_q;
        logic [CW-1:0] cnt_q;
        // A level change is accepted only after FILTER_LEN consecutive
        // synchronised samples disagree with the current filtered level.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                filt_q  <= 1'b1;
                prev_q  <= 1'b1;
                cnt_q   <= '0;
            end else begin
                sync1_q <= pin_raw[g];
                sync2_q <= sync1_q;
                prev_q  <= filt_q;
                if (sync2_q == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    filt_q <= sync2_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
        assign filt_w[g] = filt_q;
        assign prev_w[g] = prev_q;
    end

    logic sda_f, scl_f, sda_p, scl_p;
    logic scl_rise, scl_fall, start_evt, stop_evt;
    assign sda_f     = filt_w[0];
    assign scl_f     = filt_w[1];
    assign sda_p     = prev_w[0];
    assign scl_p     = prev_w[1];
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    // SCL must be high on both samples so an SDA change racing an SCL edge
    // is not mistaken for START/STOP.
    assign start_evt = ~sda_f & sda_p & scl_f & scl_p;
    assign stop_evt  = sda_f & ~sda_p & scl_f & scl_p;

    // ---------------- protocol state
    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [7:0]            tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [PW-1:0]         ptr_acc_q, ptr_acc_d;
    logic [1:0]            ptr_idx_q, ptr_idx_d;
    logic [1:0]            fcnt_q, fcnt_d;
    logic                  busy_q, busy_d;
    logic [15:0]           xfer_q, xfer_d;
    logic                  wr_q, wr_d;
    logic [7:0]            wdata_q, wdata_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            ptr_acc_q <= '0;
            ptr_idx_q <= '0;
            fcnt_q    <= '0;
            busy_q    <= 1'b0;
            xfer_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            ptr_acc_q <= ptr_acc_d;
            ptr_idx_q <= ptr_idx_d;
            fcnt_q    <= fcnt_d;
            busy_q    <= busy_d;
            xfer_q    <= xfer_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        ptr_acc_d = ptr_acc_q;
        ptr_idx_d = ptr_idx_q;
        fcnt_d    = fcnt_q;
        busy_d    = busy_q;
        xfer_d    = xfer_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;

        // Post-increment the pointer the cycle the write strobe is visible,
        // so mem_address holds the target address during the strobe.
        if (wr_q) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
        end

        unique case (state_q)
            ADDR, PTR, WRITE: begin
                if (scl_rise && bit_cnt_q != 4'd8) begin
                    shreg_d   = {shreg_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Fire the write on the 8th rise rather than waiting for
                    // the ACK slot, keeping the strobe close to the data.
                    if (state_q == WRITE && bit_cnt_q == 4'd7) begin
                        wr_d    = 1'b1;
                        wdata_d = {shreg_q[6:0], sda_f};
                    end
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    bit_cnt_d = '0;
                    if (state_q == ADDR) begin
                        if (shreg_q[7:1] == TARGET_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                            xfer_d  = '0;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (state_q == PTR) begin
                        state_d   = PTR_ACK;
                        ptr_acc_d = (ptr_acc_q << 8) | PW'(shreg_q);
                    end else begin
                        state_d = WR_ACK;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (shreg_q[0]) begin
                        state_d = RD_FETCH;
                        fcnt_d  = '0;
                    end else begin
                        state_d   = PTR;
                        ptr_idx_d = '0;
                    end
                end
            end
            PTR_ACK: begin
                if (scl_fall) begin
                    if (ptr_idx_q == 2'(PTR_BYTES - 1)) begin
                        ptr_d   = ptr_acc_q[ADDR_WIDTH-1:0];
                        state_d = WRITE;
                    end else begin
                        ptr_idx_d = ptr_idx_q + 2'd1;
                        state_d   = PTR;
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) state_d = WRITE;
            end
            RD_FETCH: begin
                // 0: issue mem_read, 1: capture readdata, 2: start driving.
                if (fcnt_q == 2'd0) begin
                    fcnt_d = 2'd1;
                end else if (fcnt_q == 2'd1) begin
                    tx_d   = mem_readdata;
                    fcnt_d = 2'd2;
                end else begin
                    state_d   = READ;
                    bit_cnt_d = '0;
                end
            end
            READ: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) state_d = RD_ACK;
                    else                   tx_d    = {tx_q[6:0], 1'b0};
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
                    if (sda_f) state_d = WAIT_STOP;
                    else       ptr_d   = ptr_q + ADDR_WIDTH'(1);
                end else if (scl_fall) begin
                    // Only reachable after an ACK; a NACK left the state.
                    state_d = RD_FETCH;
                    fcnt_d  = '0;
                end
            end
            default: ;  // IDLE, WAIT_STOP: wait for START/STOP below
        endcase

        if (stop_evt) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_evt) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
        end
    end

    // Output lines are decoded from registered state so reset releases them
    // asynchronously; STOP gates them in the detection cycle itself.
    always_comb begin
        i2c_data_oe = 1'b0;
        if (state_q == ADDR_ACK || state_q == PTR_ACK || state_q == WR_ACK)
            i2c_data_oe = 1'b1;
        else if (state_q == READ)
            i2c_data_oe = ~tx_q[7];
        if (stop_evt) i2c_data_oe = 1'b0;
    end

    assign i2c_clk_oe    = STRETCH_EN && (state_q == RD_FETCH) && !stop_evt;
    assign mem_read      = (state_q == RD_FETCH) && (fcnt_q == 2'd0);
    assign mem_address   = ptr_q;
    assign mem_write     = wr_q;
    assign mem_writedata = wdata_q;
    assign busy          = busy_q;
    assign xfer_count    = xfer_q;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench: a bit-banged I2C controller on a wired-AND bus shared by
// two targets (0x50 with 1-byte pointer, 0x52 with 2-byte 10-bit pointer).
module tb_i2c_target_regbank;

    localparam int Q = 10;  // clk cycles per quarter SCL bit

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sda_ctl = 1'b1;
    logic scl_ctl = 1'b1;
    always #5 clk = ~clk;

    logic       d1_doe, d1_coe, d1_wr, d1_rd, d1_busy;
    logic [7:0] d1_addr, d1_wdata, d1_rdata;
    logic [15:0] d1_xfer;
    logic       d2_doe, d2_coe, d2_wr, d2_rd, d2_busy;
    logic [9:0] d2_addr;
    logic [7:0] d2_wdata, d2_rdata;
    logic [15:0] d2_xfer;

    wire sda_bus = sda_ctl & ~d1_doe & ~d2_doe;
    wire scl_bus = scl_ctl & ~d1_coe & ~d2_coe;

    i2c_target_regbank #(.TARGET_ADDR(7'h50), .PTR_BYTES(1), .ADDR_WIDTH(8),
                         .FILTER_LEN(3), .STRETCH_EN(1'b1)) u_dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .i2c_data_in(sda_bus), .i2c_clk_in(scl_bus),
        .i2c_data_oe(d1_doe), .i2c_clk_oe(d1_coe),
        .mem_address(d1_addr), .mem_write(d1_wr), .mem_writedata(d1_wdata),
        .mem_read(d1_rd), .mem_readdata(d1_rdata),
        .busy(d1_busy), .xfer_count(d1_xfer));

    i2c_target_regbank #(.TARGET_ADDR(7'h52), .PTR_BYTES(2), .ADDR_WIDTH(10),
                         .FILTER_LEN(3), .STRETCH_EN(1'b1)) u_dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .i2c_data_in(sda_bus), .i2c_clk_in(scl_bus),
        .i2c_data_oe(d2_doe), .i2c_clk_oe(d2_coe),
        .mem_address(d2_addr), .mem_write(d2_wr), .mem_writedata(d2_wdata),
        .mem_read(d2_rd), .mem_readdata(d2_rdata),
        .busy(d2_busy), .xfer_count(d2_xfer));

    // RAM behind target 1 (written only by the stimulus), strobe logs.
    logic [7:0] ram [0:255];
    logic [7:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    logic [9:0] wr2_addr [0:63];
    logic [7:0] wr2_data [0:63];
    int wr_n = 0, rd_n = 0, wr2_n = 0, rd2_n = 0, str_n = 0;
    logic coe_prev = 1'b0;

    always @(posedge clk) begin
        coe_prev <= d1_coe;
        if (d1_coe && !coe_prev) str_n <= str_n + 1;
        if (d1_rd) begin
            d1_rdata <= ram[d1_addr];
            rd_n     <= rd_n + 1;
        end
        if (d1_wr) begin
            wr_addr[wr_n & 63] <= d1_addr;
            wr_data[wr_n & 63] <= d1_wdata;
            wr_n <= wr_n + 1;
        end
        if (d2_rd) begin
            d2_rdata <= 8'h00;
            rd2_n    <= rd2_n + 1;
        end
        if (d2_wr) begin
            wr2_addr[wr2_n & 63] <= d2_addr;
            wr2_data[wr2_n & 63] <= d2_wdata;
            wr2_n <= wr2_n + 1;
        end
    end

    int total = 0;
    int bad = 0;

    // ---------------- bus primitives
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_high();
        int t;
        scl_ctl = 1'b1;
        t = 0;
        while (scl_bus !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (scl_bus !== 1'b1) begin
            bad++;
            $display("FAIL scl_release got=%b want=1", scl_bus);
        end
    endtask

    task automatic clock_bit(input logic v, output logic s);
        sda_ctl = v;
        wait_clk(Q);
        scl_high();
        wait_clk(Q);
        s = sda_bus;
        wait_clk(Q);
        scl_ctl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(nack, s);
        sda_ctl = 1'b1;
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1;
        wait_clk(Q);
        scl_high();
        wait_clk(Q);
        sda_ctl = 1'b0;
        wait_clk(Q);
        scl_ctl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0;
        wait_clk(Q);
        scl_high();
        wait_clk(Q);
        sda_ctl = 1'b1;
        wait_clk(Q);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(8);
        total++; if (d1_doe !== 1'b0) begin bad++; $display("FAIL rst_data_oe got=%b want=0", d1_doe); end
        total++; if (d1_coe !== 1'b0) begin bad++; $display("FAIL rst_clk_oe got=%b want=0", d1_coe); end
        total++; if ({d1_wr, d1_rd} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b want=00", {d1_wr, d1_rd}); end
        total++; if (d1_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", d1_busy); end
        total++; if (d1_xfer !== 16'h0) begin bad++; $display("FAIL rst_xfer got=%h want=0000", d1_xfer); end
        total++; if (d1_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h want=00", d1_addr); end
        total++; if (d2_addr !== 10'h000) begin bad++; $display("FAIL rst_addr2 got=%h want=000", d2_addr); end
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        int base, base2;
        base = wr_n;
        base2 = wr2_n;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h3C, a3);
        total++; if ({a0, a1, a2, a3} !== 4'b0000) begin bad++; $display("FAIL wr_acks got=%b want=0000", {a0, a1, a2, a3}); end
        total++; if (d1_busy !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b want=1", d1_busy); end
        i2c_stop();
        wait_clk(Q);
        total++; if (d1_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop got=%b want=0", d1_busy); end
        total++; if (wr_n - base !== 2) begin bad++; $display("FAIL wr_count got=%0d want=2", wr_n - base); end
        total++; if ({wr_addr[base & 63], wr_data[base & 63]} !== 16'h10A5) begin bad++; $display("FAIL wr_first got=%h want=10a5", {wr_addr[base & 63], wr_data[base & 63]}); end
        total++; if ({wr_addr[(base + 1) & 63], wr_data[(base + 1) & 63]} !== 16'h113C) begin bad++; $display("FAIL wr_second got=%h want=113c", {wr_addr[(base + 1) & 63], wr_data[(base + 1) & 63]}); end
        total++; if (d1_xfer !== 16'd2) begin bad++; $display("FAIL wr_xfer got=%0d want=2", d1_xfer); end
        total++; if (wr2_n !== base2) begin bad++; $display("FAIL wr_other_target got=%0d want=%0d", wr2_n, base2); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        int rb, sb, wb;
        ram[8'h10] = 8'h11;
        ram[8'h11] = 8'h22;
        rb = rd_n;
        sb = str_n;
        wb = wr_n;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        i2c_start();
        send_byte(8'hA1, a2);
        recv_byte(1'b0, b0);
        recv_byte(1'b1, b1);
        wait_clk(Q);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rd_acks got=%b want=000", {a0, a1, a2}); end
        total++; if (b0 !== 8'h11) begin bad++; $display("FAIL rd_byte0 got=%h want=11", b0); end
        total++; if (b1 !== 8'h22) begin bad++; $display("FAIL rd_byte1 got=%h want=22", b1); end
        total++; if (rd_n - rb !== 2) begin bad++; $display("FAIL rd_strobes got=%0d want=2", rd_n - rb); end
        total++; if (str_n - sb !== 2) begin bad++; $display("FAIL rd_stretches got=%0d want=2", str_n - sb); end
        total++; if (d1_doe !== 1'b0) begin bad++; $display("FAIL rd_sda_after_nack got=%b want=0", d1_doe); end
        total++; if (wr_n !== wb) begin bad++; $display("FAIL rd_no_write got=%0d want=%0d", wr_n, wb); end
        i2c_stop();
        wait_clk(Q);
        total++; if (d1_busy !== 1'b0) begin bad++; $display("FAIL rd_busy_stop got=%b want=0", d1_busy); end
        total++; if (d1_xfer !== 16'd2) begin bad++; $display("FAIL rd_xfer got=%0d want=2", d1_xfer); end
    endtask

    task automatic test_nack_addr();
        logic a0, a1;
        int wb, rb, wb2;
        wb = wr_n;
        rb = rd_n;
        wb2 = wr2_n;
        i2c_start();
        send_byte(8'hA2, a0);
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL nack_addr_ack got=%b want=1", a0); end
        total++; if (d1_busy !== 1'b0) begin bad++; $display("FAIL nack_busy got=%b want=0", d1_busy); end
        send_byte(8'h10, a1);
        i2c_stop();
        wait_clk(Q);
        total++; if ({wr_n - wb, rd_n - rb, wr2_n - wb2} !== {32'd0, 32'd0, 32'd0}) begin bad++; $display("FAIL nack_strobes got=%0d/%0d/%0d want=0/0/0", wr_n - wb, rd_n - rb, wr2_n - wb2); end
        total++; if ({d1_busy, d2_busy} !== 2'b00) begin bad++; $display("FAIL nack_busy_end got=%b want=00", {d1_busy, d2_busy}); end
    endtask

    task automatic test_wrap();
        logic [4:0] ak;
        logic [4:0] ak2;
        logic a;
        int base, base2;
        base = wr_n;
        i2c_start();
        send_byte(8'hA0, a); ak[0] = a;
        send_byte(8'hFF, a); ak[1] = a;
        send_byte(8'h01, a); ak[2] = a;
        send_byte(8'h02, a); ak[3] = a;
        send_byte(8'h03, a); ak[4] = a;
        i2c_stop();
        wait_clk(Q);
        total++; if (ak !== 5'b0) begin bad++; $display("FAIL wrap_acks got=%b want=00000", ak); end
        total++; if (wr_n - base !== 3) begin bad++; $display("FAIL wrap_count got=%0d want=3", wr_n - base); end
        total++; if ({wr_addr[base & 63], wr_addr[(base + 1) & 63], wr_addr[(base + 2) & 63]} !== 24'hFF0001) begin bad++; $display("FAIL wrap_addrs got=%h want=ff0001", {wr_addr[base & 63], wr_addr[(base + 1) & 63], wr_addr[(base + 2) & 63]}); end
        total++; if ({wr_data[base & 63], wr_data[(base + 1) & 63], wr_data[(base + 2) & 63]} !== 24'h010203) begin bad++; $display("FAIL wrap_data got=%h want=010203", {wr_data[base & 63], wr_data[(base + 1) & 63], wr_data[(base + 2) & 63]}); end
        total++; if (d1_xfer !== 16'd3) begin bad++; $display("FAIL wrap_xfer got=%0d want=3", d1_xfer); end
        // 2-byte, 10-bit pointer target
        base2 = wr2_n;
        i2c_start();
        send_byte(8'hA4, a); ak2[0] = a;
        send_byte(8'h03, a); ak2[1] = a;
        send_byte(8'hFF, a); ak2[2] = a;
        send_byte(8'hAA, a); ak2[3] = a;
        send_byte(8'hBB, a); ak2[4] = a;
        i2c_stop();
        wait_clk(Q);
        total++; if (ak2 !== 5'b0) begin bad++; $display("FAIL wrap2_acks got=%b want=00000", ak2); end
        total++; if (wr2_n - base2 !== 2) begin bad++; $display("FAIL wrap2_count got=%0d want=2", wr2_n - base2); end
        total++; if ({wr2_addr[base2 & 63], wr2_data[base2 & 63]} !== 18'h3FFAA) begin bad++; $display("FAIL wrap2_first got=%h want=3ffaa", {wr2_addr[base2 & 63], wr2_data[base2 & 63]}); end
        total++; if ({wr2_addr[(base2 + 1) & 63], wr2_data[(base2 + 1) & 63]} !== 18'h000BB) begin bad++; $display("FAIL wrap2_second got=%h want=000bb", {wr2_addr[(base2 + 1) & 63], wr2_data[(base2 + 1) & 63]}); end
    endtask

    task automatic test_glitch_stop();
        logic a0, a1, a2, s;
        logic [7:0] v;
        int base;
        base = wr_n;
        v = 8'h5A;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        for (int i = 7; i >= 4; i--) clock_bit(v[i], s);
        scl_ctl = 1'b1;  // single-clk SCL glitch while SCL is low
        wait_clk(1);
        scl_ctl = 1'b0;
        wait_clk(Q);
        for (int i = 3; i >= 0; i--) clock_bit(v[i], s);
        clock_bit(1'b1, a2);
        i2c_stop();
        wait_clk(Q);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL glitch_acks got=%b want=000", {a0, a1, a2}); end
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", wr_n - base); end
        total++; if ({wr_addr[base & 63], wr_data[base & 63]} !== 16'h205A) begin bad++; $display("FAIL glitch_write got=%h want=205a", {wr_addr[base & 63], wr_data[base & 63]}); end
        // STOP after three data bits
        base = wr_n;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h30, a1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        i2c_stop();
        wait_clk(2 * Q);
        total++; if (wr_n - base !== 0) begin bad++; $display("FAIL midstop_write got=%0d want=0", wr_n - base); end
        total++; if ({d1_busy, d1_doe, d1_coe} !== 3'b000) begin bad++; $display("FAIL midstop_idle got=%b want=000", {d1_busy, d1_doe, d1_coe}); end
    endtask

    task automatic test_reset_ack();
        logic s, a0, a1, a2;
        int base;
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(i == 5 || i == 7, s);  // 0xA0
        total++; if (d1_doe !== 1'b1) begin bad++; $display("FAIL rstack_driving got=%b want=1", d1_doe); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({d1_doe, d1_coe} !== 2'b00) begin bad++; $display("FAIL rstack_async_release got=%b want=00", {d1_doe, d1_coe}); end
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(Q);
        i2c_stop();
        wait_clk(Q);
        base = wr_n;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h40, a1);
        send_byte(8'h77, a2);
        i2c_stop();
        wait_clk(Q);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rstack_acks got=%b want=000", {a0, a1, a2}); end
        total++; if (wr_n - base !== 1) begin bad++; $display("FAIL rstack_count got=%0d want=1", wr_n - base); end
        total++; if ({wr_addr[base & 63], wr_data[base & 63]} !== 16'h4077) begin bad++; $display("FAIL rstack_write got=%h want=4077", {wr_addr[base & 63], wr_data[base & 63]}); end
        total++; if (d1_xfer !== 16'd1) begin bad++; $display("FAIL rstack_xfer got=%0d want=1", d1_xfer); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i ^ 8'h5C);
        test_reset();
        test_write();
        test_read();
        test_nack_addr();
        test_wrap();
        test_glitch_stop();
        test_reset_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
